ahb_master_mux_md: RTL

AHB_MASTER_MUX_MD -- requirements
Module: ahb_master_mux_md

---
 rtl/ahb_pkg.sv | 62 ++++++
 rtl/ahb_ctrl_mux.sv | 19 +
 rtl/ahb_master_mux_md.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and payload types for the two-master AHB mux.
package ahb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // HTRANS encodings
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // HMSEL grant codes from the master arbiter
  localparam logic [1:0] HMSEL_NONE = 2'b00;
  localparam logic [1:0] HMSEL_M1   = 2'b01;
  localparam logic [1:0] HMSEL_M0   = 2'b10;

  // Address-phase grant, encoded like HMSEL
  typedef enum logic [1:0] {
    AG_NONE = 2'b00,
    AG_M1   = 2'b01,
    AG_M0   = 2'b10
  } agrant_e;

  // Data-phase owner
  typedef enum logic [1:0] {
    DP_NONE = 2'b00,
    DP_M0   = 2'b01,
    DP_M1   = 2'b10
  } dphase_e;

  // Address/control payload routed from the granted master
  typedef struct packed {
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic [3:0]        hmaster;
  } ahb_ctrl_t;

  localparam int unsigned CTRL_W = $bits(ahb_ctrl_t);

  // 11 is invalid and resolves to M0 (M0 has priority)
  function automatic agrant_e decode_hmsel(input logic [1:0] hmsel);
    agrant_e g;
    case (hmsel)
      HMSEL_M1:   g = AG_M1;
      HMSEL_NONE: g = AG_NONE;
      default:    g = AG_M0;
    endcase
    return g;
  endfunction

  // NONSEQ or SEQ
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_ctrl_mux.sv
// Two-input one-hot select mux; drives zero when neither side is selected.
module ahb_ctrl_mux #(
  parameter int unsigned W = 32
) (
  input  logic         sel0_i,
  input  logic         sel1_i,
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  output logic [W-1:0] q_o
);

  // Priority to input 0; selects are mutually exclusive in practice
  always_comb begin
    q_o = '0;
    if (sel0_i)      q_o = d0_i;
    else if (sel1_i) q_o = d1_i;
  end

endmodule

// File: rtl/ahb_master_mux_md.sv
// Two-master AHB-Lite master mux: address/control follow the address-phase
// grant, write data and responses follow the data-phase owner.
module ahb_master_mux_md
  import ahb_pkg::*;
(
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [1:0]        HMSEL,
  // master 0
  input  logic              HSELM0,
  input  logic [ADDR_W-1:0] HADDRM0,
  input  logic [1:0]        HTRANSM0,
  input  logic              HWRITEM0,
  input  logic [2:0]        HSIZEM0,
  input  logic [2:0]        HBURSTM0,
  input  logic [3:0]        HPROTM0,
  input  logic [DATA_W-1:0] HWDATAM0,
  input  logic [3:0]        HMASTER0,
  output logic              HREADYM0,
  output logic              HRESPM0,
  output logic [DATA_W-1:0] HRDATAM0,
  // master 1
  input  logic              HSELM1,
  input  logic [ADDR_W-1:0] HADDRM1,
  input  logic [1:0]        HTRANSM1,
  input  logic              HWRITEM1,
  input  logic [2:0]        HSIZEM1,
  input  logic [2:0]        HBURSTM1,
  input  logic [3:0]        HPROTM1,
  input  logic [DATA_W-1:0] HWDATAM1,
  input  logic [3:0]        HMASTER1,
  output logic              HREADYM1,
  output logic              HRESPM1,
  output logic [DATA_W-1:0] HRDATAM1,
  // slave side
  output logic [ADDR_W-1:0] HADDR_S,
  output logic [1:0]        HTRANS_S,
  output logic              HWRITE_S,
  output logic [2:0]        HSIZE_S,
  output logic [2:0]        HBURST_S,
  output logic [3:0]        HPROT_S,
  output logic [DATA_W-1:0] HWDATA_S,
  output logic [3:0]        HMASTER_S,
  input  logic [DATA_W-1:0] HRDATA_S,
  input  logic              HREADYOUT_S,
  input  logic              HRESP_S
);

  agrant_e   agrant_q, agrant_d;
  dphase_e   dphase_q, dphase_d;
  ahb_ctrl_t ctrl_m0, ctrl_m1, ctrl_s;
  logic      req_m0, req_m1;

  assign ctrl_m0 = {HADDRM0, HWRITEM0, HSIZEM0, HBURSTM0, HPROTM0, HMASTER0};
  assign ctrl_m1 = {HADDRM1, HWRITEM1, HSIZEM1, HBURSTM1, HPROTM1, HMASTER1};
  assign req_m0  = HSELM0 & trans_active(HTRANSM0);
  assign req_m1  = HSELM1 & trans_active(HTRANSM1);

  // Address/control mux steered by the address-phase grant
  ahb_ctrl_mux #(.W(CTRL_W)) u_addr_mux (
    .sel0_i (agrant_q == AG_M0),
    .sel1_i (agrant_q == AG_M1),
    .d0_i   (ctrl_m0),
    .d1_i   (ctrl_m1),
    .q_o    (ctrl_s)
  );

  // Write-data mux steered by the data-phase owner
  ahb_ctrl_mux #(.W(DATA_W)) u_wdata_mux (
    .sel0_i (dphase_q == DP_M0),
    .sel1_i (dphase_q == DP_M1),
    .d0_i   (HWDATAM0),
    .d1_i   (HWDATAM1),
    .q_o    (HWDATA_S)
  );

  assign HADDR_S   = ctrl_s.haddr;
  assign HWRITE_S  = ctrl_s.hwrite;
  assign HSIZE_S   = ctrl_s.hsize;
  assign HBURST_S  = ctrl_s.hburst;
  assign HPROT_S   = ctrl_s.hprot;
  assign HMASTER_S = ctrl_s.hmaster;
  assign HRDATAM0  = HRDATA_S;
  assign HRDATAM1  = HRDATA_S;

  // Slave HTRANS: only a granted, selected master reaches the bus; forced idle in reset
  always_comb begin
    HTRANS_S = HTRANS_IDLE;
    if (!HRESET) begin
      if (agrant_q == AG_M0 && HSELM0)      HTRANS_S = HTRANSM0;
      else if (agrant_q == AG_M1 && HSELM1) HTRANS_S = HTRANSM1;
    end
  end

  // Grant and data-phase state registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      agrant_q <= AG_M0;
      dphase_q <= DP_NONE;
    end else begin
      agrant_q <= agrant_d;
      dphase_q <= dphase_d;
    end
  end

  // Next-state: both registers advance only when the slave is ready
  always_comb begin
    agrant_d = agrant_q;
    dphase_d = dphase_q;
    if (HREADYOUT_S) begin
      agrant_d = decode_hmsel(HMSEL);
      dphase_d = DP_NONE;
      if (trans_active(HTRANS_S)) begin
        if (agrant_q == AG_M0)      dphase_d = DP_M0;
        else if (agrant_q == AG_M1) dphase_d = DP_M1;
      end
    end
  end

  // Per-master response: owner sees the slave, blocked requesters stall, idle masters see ready
  always_comb begin
    HREADYM0 = 1'b1;
    HRESPM0  = 1'b0;
    HREADYM1 = 1'b1;
    HRESPM1  = 1'b0;
    if (!HRESET) begin
      if (dphase_q == DP_M0 || (agrant_q == AG_M0 && dphase_q == DP_NONE)) begin
        HREADYM0 = HREADYOUT_S;
        HRESPM0  = HRESP_S;
      end else if (req_m0) begin
        HREADYM0 = (agrant_q == AG_M0) ? HREADYOUT_S : 1'b0;
      end
      if (dphase_q == DP_M1 || (agrant_q == AG_M1 && dphase_q == DP_NONE)) begin
        HREADYM1 = HREADYOUT_S;
        HRESPM1  = HRESP_S;
      end else if (req_m1) begin
        HREADYM1 = (agrant_q == AG_M1) ? HREADYOUT_S : 1'b0;
      end
    end
  end

endmodule
